// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: special digit codes,
// active-low glyph patterns (seg[0]=a ... seg[6]=g) and the scan FSM encoding.
package seg7_pkg;

    localparam logic [7:0] CODE_MINUS = 8'h10;
    localparam logic [7:0] CODE_BLANK = 8'h11;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_F     = 7'h0E;
    localparam logic [6:0] GLYPH_MINUS = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // A code counts as a "leading zero" candidate if it shows 0 or nothing.
    // Every code above CODE_MINUS decodes to blank.
    function automatic logic is_zero_or_blank(input logic [7:0] code);
        return (code == 8'h00) || (code > CODE_MINUS);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low seven-segment glyph decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [7:0] code,
    output logic [6:0] glyph
);

    // Map the 8-bit code to its glyph; anything unrecognised is blank.
    always_comb begin
        glyph = GLYPH_BLANK;
        case (code)
            8'h00:      glyph = GLYPH_0;
            8'h01:      glyph = GLYPH_1;
            8'h02:      glyph = GLYPH_2;
            8'h03:      glyph = GLYPH_3;
            8'h04:      glyph = GLYPH_4;
            8'h05:      glyph = GLYPH_5;
            8'h06:      glyph = GLYPH_6;
            8'h07:      glyph = GLYPH_7;
            8'h08:      glyph = GLYPH_8;
            8'h09:      glyph = GLYPH_9;
            8'h0A:      glyph = GLYPH_A;
            8'h0B:      glyph = GLYPH_B;
            8'h0C:      glyph = GLYPH_C;
            8'h0D:      glyph = GLYPH_D;
            8'h0E:      glyph = GLYPH_E;
            8'h0F:      glyph = GLYPH_F;
            CODE_MINUS: glyph = GLYPH_MINUS;
            default:    glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver. Digit codes are captured once per
// frame so a conversion in progress upstream never tears the display.
//
//   state | meaning
//   ------+-----------------------------------------------------
//   IDLE  | display disabled, outputs dark, counters cleared
//   GUARD | start of a slot, all anodes off to avoid ghosting
//   DRIVE | anode of slot_idx on, its glyph on the segments
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 1000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dig_0_ans,
    input  logic [7:0] dig_1_ans,
    input  logic [7:0] dig_2_ans,
    input  logic [7:0] dig_3_ans,
    input  logic       disp_en,
    input  logic       blank_lz,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int               CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    scan_state_t        state;
    logic [1:0]         slot_idx;
    logic [CNT_W-1:0]   slot_cnt;
    logic [3:0][7:0]    snap;
    logic [3:0]         lz_blank;
    logic [7:0]         slot_code;
    logic [6:0]         slot_glyph;

    // Leading-zero blanking ripples down from the leftmost digit; digit 0
    // always shows. blank_lz is used live, the digit codes come from the snapshot.
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = blank_lz && is_zero_or_blank(snap[3]);
        lz_blank[2] = lz_blank[3] && is_zero_or_blank(snap[2]);
        lz_blank[1] = lz_blank[2] && is_zero_or_blank(snap[1]);
    end

    assign slot_code = lz_blank[slot_idx] ? CODE_BLANK : snap[slot_idx];

    seg7_decode u_decode (
        .code  (slot_code),
        .glyph (slot_glyph)
    );

    // Scan FSM: slot timing, digit rotation and once-per-frame snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            slot_idx   <= 2'd0;
            slot_cnt   <= '0;
            snap       <= {4{CODE_BLANK}};
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (!disp_en) begin
                state    <= IDLE;
                slot_idx <= 2'd0;
                slot_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        snap       <= {dig_3_ans, dig_2_ans, dig_1_ans, dig_0_ans};
                        frame_tick <= 1'b1;
                        slot_idx   <= 2'd0;
                        slot_cnt   <= '0;
                        state      <= GUARD;
                    end
                    GUARD: begin
                        slot_cnt <= slot_cnt + CNT_ONE;
                        if (slot_cnt == GUARD_LAST) begin
                            state <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        if (slot_cnt == SLOT_LAST) begin
                            slot_cnt <= '0;
                            slot_idx <= slot_idx + 2'd1;
                            state    <= GUARD;
                            if (slot_idx == 2'd3) begin
                                snap       <= {dig_3_ans, dig_2_ans, dig_1_ans, dig_0_ans};
                                frame_tick <= 1'b1;
                            end
                        end else begin
                            slot_cnt <= slot_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Registered pad drivers; disp_en low darkens on the very next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= GLYPH_BLANK;
            dp  <= 1'b1;
        end else if (disp_en && state == DRIVE) begin
            an  <= ~(4'b0001 << slot_idx);
            seg <= slot_glyph;
            dp  <= ~dp_mask[slot_idx];
        end else begin
            an  <= 4'hF;
            seg <= GLYPH_BLANK;
            dp  <= 1'b1;
        end
    end

endmodule
